// File: rtl/plab4_net_router_domain_sched.sv
// Shares one router input port's arbiter request lines between two security domains.
// TDM mode rotates ownership on fixed slots; RR mode is work-conserving round-robin.
module plab4_net_router_domain_sched #(
  parameter  int p_slot_cycles = 4,
  localparam int c_cnt_nbits   = $clog2(p_slot_cycles)
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tdm_en,
  input  logic [2:0] reqs_d1,
  input  logic [2:0] reqs_d2,
  input  logic [2:0] grants,
  output logic [2:0] reqs,
  output logic [2:0] grants_d1,
  output logic [2:0] grants_d2,
  output logic       domain,
  output logic       xfer
);

  localparam logic [c_cnt_nbits-1:0] c_slot_last = c_cnt_nbits'(p_slot_cycles - 1);

  logic                   owner;
  logic [c_cnt_nbits-1:0] slot_cnt;
  logic                   rr_ptr;
  logic                   last_dom;
  logic                   tdm_q;

  logic       tdm_mode;
  logic       sel;
  logic [2:0] fwd;
  logic       xfer_int;

  // TDM only once tdm_en has been seen for a full cycle; the entry cycle runs as RR
  assign tdm_mode = tdm_en & tdm_q;

  always_comb begin
    sel = last_dom;
    if (tdm_mode)                   sel = owner;
    else if ((|reqs_d1) && !(|reqs_d2)) sel = 1'b0;
    else if (!(|reqs_d1) && (|reqs_d2)) sel = 1'b1;
    else if ((|reqs_d1) && (|reqs_d2))  sel = rr_ptr;
  end

  assign fwd      = sel ? reqs_d2 : reqs_d1;
  assign xfer_int = |(fwd & grants);

  assign reqs      = reset ? 3'b000 : fwd;
  assign grants_d1 = (reset || sel)  ? 3'b000 : grants;
  assign grants_d2 = (reset || !sel) ? 3'b000 : grants;
  assign domain    = reset ? 1'b0 : sel;
  assign xfer      = reset ? 1'b0 : xfer_int;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      owner    <= 1'b0;
      slot_cnt <= '0;
      rr_ptr   <= 1'b0;
      last_dom <= 1'b0;
      tdm_q    <= 1'b0;
    end else begin
      tdm_q <= tdm_en;
      if (tdm_mode) begin
        if (slot_cnt == c_slot_last) begin
          slot_cnt <= '0;
          owner    <= ~owner;
        end else begin
          slot_cnt <= slot_cnt + 1'b1;
        end
      end else begin
        last_dom <= sel;
        if (xfer_int) rr_ptr <= ~sel;
        if (tdm_en && !tdm_q) begin
          owner    <= 1'b0;
          slot_cnt <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_plab4_net_router_domain_sched.sv
// Scoreboard bench: driver pushes model-predicted outputs, negedge monitor pops and compares.
module tb_plab4_net_router_domain_sched;
  localparam int P = 4;

  logic       clk = 0;
  logic       reset;
  logic       tdm_en;
  logic [2:0] reqs_d1, reqs_d2, grants;
  logic [2:0] reqs, grants_d1, grants_d2;
  logic       domain, xfer;

  plab4_net_router_domain_sched #(.p_slot_cycles(P)) dut (
    .clk(clk), .reset(reset), .tdm_en(tdm_en),
    .reqs_d1(reqs_d1), .reqs_d2(reqs_d2), .grants(grants),
    .reqs(reqs), .grants_d1(grants_d1), .grants_d2(grants_d2),
    .domain(domain), .xfer(xfer)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] reqs;
    logic [2:0] gd1;
    logic [2:0] gd2;
    logic       dom;
    logic       xfer;
  } exp_t;

  exp_t q[$];
  int n_cmp = 0, n_bad = 0;
  int step_no = 0;

  // reference state
  int m_owner, m_cnt, m_ptr, m_last, m_tq;

  task automatic clear_model();
    m_owner = 0; m_cnt = 0; m_ptr = 0; m_last = 0; m_tq = 0;
  endtask

  // Drive one cycle of inputs, predict outputs, then advance the model at the clock edge.
  task automatic step(input bit rst, input bit tdm, input logic [2:0] r1, input logic [2:0] r2,
                      input logic [2:0] g, input bit echo);
    exp_t e;
    int dom, tmode;
    logic [2:0] fw, gg;
    if (rst) clear_model();
    tmode = (tdm && m_tq) ? 1 : 0;
    if (tmode)                       dom = m_owner;
    else if (r1 != 0 && r2 == 0)     dom = 0;
    else if (r1 == 0 && r2 != 0)     dom = 1;
    else if (r1 != 0 && r2 != 0)     dom = m_ptr;
    else                             dom = m_last;
    fw = (dom == 1) ? r2 : r1;
    gg = echo ? fw : g;
    reset = rst; tdm_en = tdm; reqs_d1 = r1; reqs_d2 = r2; grants = gg;
    if (rst) e = '0;
    else begin
      e.reqs = fw;
      e.gd1  = (dom == 0) ? gg : 3'b000;
      e.gd2  = (dom == 1) ? gg : 3'b000;
      e.dom  = dom[0];
      e.xfer = |(fw & gg);
    end
    q.push_back(e);
    @(posedge clk);
    if (!rst) begin
      m_tq = tdm;
      if (tmode) begin
        if (m_cnt == P - 1) begin m_cnt = 0; m_owner = 1 - m_owner; end
        else m_cnt = m_cnt + 1;
      end else begin
        m_last = dom;
        if (e.xfer) m_ptr = 1 - dom;
        if (tdm && !m_tq_prev(tdm, tmode)) begin m_owner = 0; m_cnt = 0; end
      end
    end
    #1;
    step_no++;
  endtask

  // In a non-TDM cycle with tdm_en high, the registered copy was necessarily low.
  function automatic bit m_tq_prev(input bit tdm, input int tmode);
    return tdm && (tmode != 0);
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      n_cmp++;
      if ({reqs, grants_d1, grants_d2, domain, xfer} !== e) begin
        n_bad++;
        $display("FAIL step%0d outputs: got reqs=%b gd1=%b gd2=%b dom=%b xfer=%b, want reqs=%b gd1=%b gd2=%b dom=%b xfer=%b",
                 step_no, reqs, grants_d1, grants_d2, domain, xfer, e.reqs, e.gd1, e.gd2, e.dom, e.xfer);
      end
    end
  end

  initial begin
    reset = 1; tdm_en = 0; reqs_d1 = 0; reqs_d2 = 0; grants = 0;
    clear_model();
    #1;
    @(posedge clk); #1;
    // reset state, then release with d1 requesting; reset mid-operation
    step(1, 0, 3'b010, 3'b000, 3'b000, 0);
    step(0, 0, 3'b010, 3'b000, 3'b000, 0);
    step(0, 0, 3'b011, 3'b101, 3'b001, 0);
    step(1, 0, 3'b010, 3'b000, 3'b010, 0);
    step(0, 0, 3'b010, 3'b000, 3'b000, 0);
    // RR contention with grant echo
    for (int i = 0; i < 6; i++) step(0, 0, 3'b001, 3'b100, 3'b000, 1);
    // no-grant hold then grant
    step(1, 0, 3'b000, 3'b000, 3'b000, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 3'b001, 3'b100, 3'b000, 0);
    step(0, 0, 3'b001, 3'b100, 3'b001, 0);
    step(0, 0, 3'b001, 3'b100, 3'b000, 0);
    // TDM rotation from reset, only d2 requesting
    step(1, 1, 3'b000, 3'b010, 3'b111, 0);
    for (int i = 0; i < 12; i++) step(0, 1, 3'b000, 3'b010, 3'b111, 0);
    // mode switch with last RR selection d2
    step(0, 0, 3'b000, 3'b100, 3'b100, 0);
    step(0, 0, 3'b000, 3'b100, 3'b000, 0);
    for (int i = 0; i < 10; i++) step(0, 1, 3'b001, 3'b100, 3'b000, 0);
    // slot boundary: d1 granted on the last slot cycle
    step(1, 1, 3'b000, 3'b000, 3'b000, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 3'b001, 3'b001, 3'b001, 0);
    step(0, 1, 3'b001, 3'b001, 3'b001, 0);
    step(0, 0, 3'b001, 3'b001, 3'b001, 0);
    // randomized traffic
    begin
      bit t; t = 0;
      for (int i = 0; i < 3000; i++) begin
        logic [2:0] r1, r2, g;
        bit rs;
        if ($urandom_range(0, 24) == 0) t = ~t;
        rs = ($urandom_range(0, 199) == 0);
        r1 = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom);
        r2 = ($urandom_range(0, 2) == 0) ? 3'b000 : 3'($urandom);
        g  = 3'($urandom);
        step(rs, t, r1, r2, g, $urandom_range(0, 3) == 0);
      end
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
